// File: rtl/zap_predecode_branch_pkg.sv
// Shared definitions for the predecode branch stage: predictor taken-state
// encodings (also used by the predictor stage), ARM B/BL opcode fields and
// the stage FSM encoding.
package zap_predecode_branch_pkg;

    // 2-bit saturating predictor states.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // ARM B/BL: bits [27:25] = 101; condition 1111 is the unconditional
    // (BLX) space and must not be treated as a plain branch.
    localparam logic [2:0] BR_OPCODE = 3'b101;
    localparam logic [3:0] COND_NV   = 4'b1111;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } fsm_state_t;

    // Weak or strong taken means the predictor wants a redirect.
    function automatic logic taken_predicted(input logic [1:0] state);
        logic r;
        unique case (state)
            SNT, WNT: r = 1'b0;
            WT, ST:   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/zap_predecode_branch_target_calc.sv
// Combinational B/BL decode: flags a branch encoding and computes
// target = pc_plus_8 + sign_extend(imm24) * 4, wrapping at PC_WIDTH bits.
module zap_branch_target_calc
    import zap_predecode_branch_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [3:0]          i_cond,
    input  logic [2:0]          i_opcode,
    input  logic [23:0]         i_imm24,
    input  logic [PC_WIDTH-1:0] i_pc_plus_8,
    output logic [PC_WIDTH-1:0] o_target,
    output logic                o_is_branch
);

    logic signed [25:0]  offset_word;
    logic [PC_WIDTH-1:0] offset;

    // Word offset is sign-extended by the width cast of a signed value.
    assign offset_word = signed'({i_imm24, 2'b00});
    assign offset      = PC_WIDTH'(offset_word);
    assign o_target    = i_pc_plus_8 + offset;
    assign o_is_branch = (i_opcode == BR_OPCODE) && (i_cond != COND_NV);

endmodule

// File: rtl/zap_predecode_branch.sv
// Predecode branch stage: sits after the predictor RAM, redirects fetch one
// cycle early for B/BL predicted taken, squashes the single wrong-path
// instruction that follows, and registers everything toward decode.
module zap_predecode_branch
    import zap_predecode_branch_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clear_from_writeback,
    input  logic                 i_data_stall,
    input  logic                 i_clear_from_alu,
    input  logic                 i_stall_from_shifter,
    input  logic                 i_stall_from_issue,
    input  logic                 i_cpsr_t,
    input  logic [31:0]          i_inst,
    input  logic                 i_val,
    input  logic                 i_abt,
    input  logic [PC_WIDTH-1:0]  i_pc,
    input  logic [PC_WIDTH-1:0]  i_pc_plus_8,
    input  logic [1:0]           i_taken,
    output logic [31:0]          o_inst_ff,
    output logic                 o_val_ff,
    output logic                 o_abt_ff,
    output logic [PC_WIDTH-1:0]  o_pc_ff,
    output logic [PC_WIDTH-1:0]  o_pc_plus_8_ff,
    output logic [1:0]           o_taken_ff,
    output logic                 o_clear_from_decode,
    output logic [PC_WIDTH-1:0]  o_pc_from_decode,
    output logic [CNT_WIDTH-1:0] o_pred_cnt
);

    localparam logic [PC_WIDTH-1:0] PC8_RST = PC_WIDTH'(8);

    fsm_state_t          state;
    logic [PC_WIDTH-1:0] target;
    logic                is_branch;
    logic                predict;
    logic                do_clear;
    logic                do_hold;

    zap_branch_target_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target (
        .i_cond      (i_inst[31:28]),
        .i_opcode    (i_inst[27:25]),
        .i_imm24     (i_inst[23:0]),
        .i_pc_plus_8 (i_pc_plus_8),
        .o_target    (target),
        .o_is_branch (is_branch)
    );

    // Predict only real ARM-state, non-aborted branches the predictor likes.
    assign predict = i_val && !i_abt && !i_cpsr_t && is_branch && taken_predicted(i_taken);

    // Writeback clear beats everything; a data stall beats the ALU clear.
    assign do_clear = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
    assign do_hold  = i_data_stall || i_stall_from_shifter || i_stall_from_issue;

    // Pipeline registers, redirect pulse, prediction counter and FSM.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_inst_ff           <= '0;
            o_val_ff            <= 1'b0;
            o_abt_ff            <= 1'b0;
            o_pc_ff             <= '0;
            o_pc_plus_8_ff      <= PC8_RST;
            o_taken_ff          <= SNT;
            o_clear_from_decode <= 1'b0;
            o_pc_from_decode    <= '0;
            o_pred_cnt          <= '0;
            state               <= IDLE;
        end else if (do_clear) begin
            // Flush: counter survives, everything else back to reset values.
            o_inst_ff           <= '0;
            o_val_ff            <= 1'b0;
            o_abt_ff            <= 1'b0;
            o_pc_ff             <= '0;
            o_pc_plus_8_ff      <= PC8_RST;
            o_taken_ff          <= SNT;
            o_clear_from_decode <= 1'b0;
            o_pc_from_decode    <= '0;
            state               <= IDLE;
        end else if (do_hold) begin
            // Keep the redirect a single-cycle pulse; SQUASH persists.
            o_clear_from_decode <= 1'b0;
        end else begin
            o_inst_ff      <= i_inst;
            o_abt_ff       <= i_abt;
            o_pc_ff        <= i_pc;
            o_pc_plus_8_ff <= i_pc_plus_8;
            o_taken_ff     <= i_taken;
            if (state == SQUASH) begin
                // Instruction fetched behind the predicted branch is wrong-path.
                o_val_ff            <= 1'b0;
                o_clear_from_decode <= 1'b0;
                state               <= IDLE;
            end else if (predict) begin
                o_val_ff            <= i_val;
                o_clear_from_decode <= 1'b1;
                o_pc_from_decode    <= target;
                if (o_pred_cnt != '1)
                    o_pred_cnt <= o_pred_cnt + CNT_WIDTH'(1);
                state               <= SQUASH;
            end else begin
                o_val_ff            <= i_val;
                o_clear_from_decode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zap_predecode_branch.sv
// Bench for zap_predecode_branch: directed scenarios plus randomized traffic
// against a behavioural model. Counter width is narrowed so saturation is
// reachable in a short run.
module tb_zap_predecode_branch;

    localparam int PW      = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_reset_n = 1'b0;
    logic             i_clear_from_writeback = 1'b0;
    logic             i_data_stall = 1'b0;
    logic             i_clear_from_alu = 1'b0;
    logic             i_stall_from_shifter = 1'b0;
    logic             i_stall_from_issue = 1'b0;
    logic             i_cpsr_t = 1'b0;
    logic [31:0]      i_inst = '0;
    logic             i_val = 1'b0;
    logic             i_abt = 1'b0;
    logic [PW-1:0]    i_pc = '0;
    logic [PW-1:0]    i_pc_plus_8 = '0;
    logic [1:0]       i_taken = '0;
    logic [31:0]      o_inst_ff;
    logic             o_val_ff;
    logic             o_abt_ff;
    logic [PW-1:0]    o_pc_ff;
    logic [PW-1:0]    o_pc_plus_8_ff;
    logic [1:0]       o_taken_ff;
    logic             o_clear_from_decode;
    logic [PW-1:0]    o_pc_from_decode;
    logic [CNT_W-1:0] o_pred_cnt;

    int errs = 0;
    int checks = 0;

    // Model of the registered outputs.
    logic [31:0]   m_inst;
    logic          m_val, m_abt, m_clr;
    logic [PW-1:0] m_pc, m_pc8, m_tgt;
    logic [1:0]    m_taken;
    int            m_cnt;
    bit            m_wrong_path;   // next advancing instruction gets dropped

    zap_predecode_branch #(.PC_WIDTH(PW), .CNT_WIDTH(CNT_W)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_cpsr_t(i_cpsr_t),
        .i_inst(i_inst), .i_val(i_val), .i_abt(i_abt), .i_pc(i_pc),
        .i_pc_plus_8(i_pc_plus_8), .i_taken(i_taken),
        .o_inst_ff(o_inst_ff), .o_val_ff(o_val_ff), .o_abt_ff(o_abt_ff),
        .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff),
        .o_clear_from_decode(o_clear_from_decode), .o_pc_from_decode(o_pc_from_decode),
        .o_pred_cnt(o_pred_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_flush(input bit keep_cnt);
        m_inst = '0; m_val = 0; m_abt = 0; m_pc = '0; m_pc8 = 32'd8;
        m_taken = 0; m_clr = 0; m_tgt = '0; m_wrong_path = 0;
        if (!keep_cnt) m_cnt = 0;
    endtask

    // One clock of the spec rules applied to the current inputs.
    task automatic model_step();
        bit pred;
        int off;
        string act;
        pred = i_val && !i_abt && !i_cpsr_t && (i_inst[27:25] == 3'b101) &&
               (i_inst[31:28] != 4'hF) && (i_taken >= 2);
        if (i_clear_from_writeback)                       act = "clear";
        else if (i_data_stall)                            act = "hold";
        else if (i_clear_from_alu)                        act = "clear";
        else if (i_stall_from_shifter || i_stall_from_issue) act = "hold";
        else                                              act = "adv";
        if (act == "clear") model_flush(1);
        else if (act == "hold") m_clr = 0;
        else begin
            m_inst = i_inst; m_abt = i_abt; m_pc = i_pc; m_pc8 = i_pc_plus_8; m_taken = i_taken;
            if (m_wrong_path) begin
                m_val = 0; m_clr = 0; m_wrong_path = 0;
            end else begin
                m_val = i_val;
                m_clr = pred;
                if (pred) begin
                    off   = int'($signed(i_inst[23:0]));
                    m_tgt = i_pc_plus_8 + 32'(off * 4);
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_wrong_path = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic quiet_ctrl();
        i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_from_shifter = 0; i_stall_from_issue = 0; i_cpsr_t = 0; i_abt = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [1:0] taken, input logic val);
        i_pc = pc; i_pc_plus_8 = pc + 32'd8; i_inst = inst; i_taken = taken; i_val = val;
    endtask

    task automatic test_reset();
        i_reset_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        model_flush(0);
        checks++; if (o_val_ff !== 1'b0 || o_inst_ff !== 32'd0 || o_pc_ff !== 32'd0) begin
            errs++; $display("FAIL reset_pipe val=%0b inst=%h pc=%h exp 0/0/0", o_val_ff, o_inst_ff, o_pc_ff); end
        checks++; if (o_pc_plus_8_ff !== 32'd8) begin
            errs++; $display("FAIL reset_pc8 got=%h exp=8", o_pc_plus_8_ff); end
        checks++; if (o_clear_from_decode !== 1'b0 || o_pred_cnt !== 8'd0 || o_pc_from_decode !== 32'd0) begin
            errs++; $display("FAIL reset_redir clr=%0b cnt=%0d tgt=%h exp 0/0/0", o_clear_from_decode, o_pred_cnt, o_pc_from_decode); end
        @(negedge i_clk);
        i_reset_n = 1;
    endtask

    task automatic test_forward_branch();
        quiet_ctrl();
        drive(32'h100, 32'hEA000010, 2'd3, 1);
        tick();
        checks++; if (o_clear_from_decode !== 1'b1 || o_pc_from_decode !== 32'h148) begin
            errs++; $display("FAIL fwd_redir clr=%0b tgt=%h exp 1/148", o_clear_from_decode, o_pc_from_decode); end
        checks++; if (o_pred_cnt !== 8'd1 || o_val_ff !== 1'b1 || o_taken_ff !== 2'd3) begin
            errs++; $display("FAIL fwd_state cnt=%0d val=%0b taken=%0d exp 1/1/3", o_pred_cnt, o_val_ff, o_taken_ff); end
        drive(32'h104, 32'hE1A00000, 2'd0, 1);
        tick();
        checks++; if (o_val_ff !== 1'b0 || o_clear_from_decode !== 1'b0 || o_pc_ff !== 32'h104) begin
            errs++; $display("FAIL fwd_squash val=%0b clr=%0b pc=%h exp 0/0/104", o_val_ff, o_clear_from_decode, o_pc_ff); end
    endtask

    task automatic test_backward_branch();
        drive(32'h200, 32'hEAFFFFFE, 2'd2, 1);
        tick();
        checks++; if (o_clear_from_decode !== 1'b1 || o_pc_from_decode !== 32'h200 || o_pc_ff !== 32'h200) begin
            errs++; $display("FAIL bwd_redir clr=%0b tgt=%h pc=%h exp 1/200/200", o_clear_from_decode, o_pc_from_decode, o_pc_ff); end
        drive(32'h204, 32'hE1A00000, 2'd0, 1);
        tick();
        checks++; if (o_val_ff !== 1'b0 || o_pred_cnt !== 8'd2) begin
            errs++; $display("FAIL bwd_squash val=%0b cnt=%0d exp 0/2", o_val_ff, o_pred_cnt); end
    endtask

    task automatic test_no_predict();
        logic [31:0] insts [4] = '{32'hEA000010, 32'hEA000010, 32'hEA000010, 32'hFA000010};
        logic [1:0]  tks   [4] = '{2'd1, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 4; k++) begin
            quiet_ctrl();
            drive(32'h300 + 32'(k * 4), insts[k], tks[k], 1);
            i_abt = (k == 1); i_cpsr_t = (k == 2);
            tick();
            checks++; if (o_clear_from_decode !== 1'b0 || o_val_ff !== 1'b1 || o_taken_ff !== tks[k] || o_abt_ff !== (k == 1)) begin
                errs++; $display("FAIL nopred_%0d clr=%0b val=%0b taken=%0d abt=%0b", k, o_clear_from_decode, o_val_ff, o_taken_ff, o_abt_ff); end
        end
        quiet_ctrl();
        checks++; if (o_pred_cnt !== 8'd2) begin
            errs++; $display("FAIL nopred_cnt got=%0d exp=2", o_pred_cnt); end
    endtask

    task automatic test_stall_in_squash();
        drive(32'h400, 32'hEA000000, 2'd3, 1);
        tick();
        checks++; if (o_clear_from_decode !== 1'b1 || o_pc_from_decode !== 32'h408) begin
            errs++; $display("FAIL stall_redir clr=%0b tgt=%h exp 1/408", o_clear_from_decode, o_pc_from_decode); end
        i_stall_from_issue = 1;
        drive(32'h404, 32'hEA000000, 2'd3, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_clear_from_decode !== 1'b0 || o_pc_ff !== 32'h400 || o_val_ff !== 1'b1) begin
                errs++; $display("FAIL stall_hold_%0d clr=%0b pc=%h val=%0b exp 0/400/1", k, o_clear_from_decode, o_pc_ff, o_val_ff); end
        end
        i_stall_from_issue = 0;
        tick();
        checks++; if (o_val_ff !== 1'b0 || o_clear_from_decode !== 1'b0 || o_pc_ff !== 32'h404 || o_pred_cnt !== 8'd3) begin
            errs++; $display("FAIL stall_squash val=%0b clr=%0b pc=%h cnt=%0d exp 0/0/404/3", o_val_ff, o_clear_from_decode, o_pc_ff, o_pred_cnt); end
    endtask

    task automatic test_alu_clear();
        drive(32'h500, 32'hEA000010, 2'd3, 1);
        i_clear_from_alu = 1;
        tick();
        checks++; if (o_val_ff !== 1'b0 || o_clear_from_decode !== 1'b0 || o_pc_plus_8_ff !== 32'd8 || o_pred_cnt !== 8'd3) begin
            errs++; $display("FAIL alu_clear val=%0b clr=%0b pc8=%h cnt=%0d exp 0/0/8/3", o_val_ff, o_clear_from_decode, o_pc_plus_8_ff, o_pred_cnt); end
        i_clear_from_alu = 0;
        drive(32'h600, 32'hE1A00000, 2'd0, 1);
        tick();
        i_clear_from_alu = 1; i_data_stall = 1;
        drive(32'h700, 32'hE1A00001, 2'd0, 1);
        tick();
        checks++; if (o_val_ff !== 1'b1 || o_pc_plus_8_ff !== 32'h608 || o_inst_ff !== 32'hE1A00000) begin
            errs++; $display("FAIL dstall_beats_alu val=%0b pc8=%h inst=%h exp 1/608/E1A00000", o_val_ff, o_pc_plus_8_ff, o_inst_ff); end
        quiet_ctrl();
    endtask

    task automatic test_async_reset();
        drive(32'h800, 32'hEA000004, 2'd3, 1);
        tick();
        #2 i_reset_n = 0;
        #1;
        model_flush(0);
        checks++; if (o_val_ff !== 1'b0 || o_clear_from_decode !== 1'b0 || o_pc_ff !== 32'd0 || o_pc_plus_8_ff !== 32'd8 || o_pred_cnt !== 8'd0) begin
            errs++; $display("FAIL async_rst val=%0b clr=%0b pc=%h pc8=%h cnt=%0d", o_val_ff, o_clear_from_decode, o_pc_ff, o_pc_plus_8_ff, o_pred_cnt); end
        @(negedge i_clk);
        i_reset_n = 1;
        drive(32'h900, 32'hEA000004, 2'd3, 1);
        tick();
        checks++; if (o_clear_from_decode !== 1'b1 || o_pc_from_decode !== 32'h918) begin
            errs++; $display("FAIL post_rst_idle clr=%0b tgt=%h exp 1/918", o_clear_from_decode, o_pc_from_decode); end
        drive(32'h904, 32'h0, 2'd0, 0);
        tick();
    endtask

    task automatic test_saturation();
        int fails = 0;
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            drive(32'h1000, 32'hEA000001, 2'd3, 1);
            tick();
            if (o_clear_from_decode !== 1'b1 || o_pred_cnt !== m_cnt[CNT_W-1:0]) fails++;
            drive(32'h1004, 32'h0, 2'd0, 0);
            tick();
        end
        checks++; if (fails != 0) begin
            errs++; $display("FAIL sat_sequence bad_cycles=%0d exp 0", fails); end
        checks++; if (o_pred_cnt !== 8'hFF) begin
            errs++; $display("FAIL sat_value got=%h exp=ff", o_pred_cnt); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] inst;
            inst = $urandom;
            if ($urandom_range(9) < 6) inst[27:25] = 3'b101;
            if ($urandom_range(9) == 0) inst[31:28] = 4'hF;
            drive({$urandom_range(32'hFFFF), 2'b00}, inst, 2'($urandom_range(3)), $urandom_range(9) < 8);
            i_abt = ($urandom_range(9) == 0);
            i_cpsr_t = ($urandom_range(9) == 0);
            i_clear_from_writeback = ($urandom_range(31) == 0);
            i_data_stall = ($urandom_range(11) == 0);
            i_clear_from_alu = ($urandom_range(15) == 0);
            i_stall_from_shifter = ($urandom_range(15) == 0);
            i_stall_from_issue = ($urandom_range(11) == 0);
            tick();
            checks++;
            if (o_inst_ff !== m_inst || o_val_ff !== m_val || o_abt_ff !== m_abt ||
                o_pc_ff !== m_pc || o_pc_plus_8_ff !== m_pc8 || o_taken_ff !== m_taken ||
                o_clear_from_decode !== m_clr || o_pc_from_decode !== m_tgt ||
                o_pred_cnt !== m_cnt[CNT_W-1:0]) begin
                errs++;
                if (bad++ < 10)
                    $display("FAIL rnd cyc=%0d got val=%0b clr=%0b pc=%h tgt=%h cnt=%0d exp val=%0b clr=%0b pc=%h tgt=%h cnt=%0d",
                             c, o_val_ff, o_clear_from_decode, o_pc_ff, o_pc_from_decode, o_pred_cnt,
                             m_val, m_clr, m_pc, m_tgt, m_cnt);
            end
        end
        quiet_ctrl();
    endtask

    initial begin
        test_reset();
        test_forward_branch();
        test_backward_branch();
        test_no_predict();
        test_stall_in_squash();
        test_alu_clear();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/zap_predecode_branch.md
Name: zap_predecode_branch

Overview:
- Stage directly downstream of the branch predictor RAM/pipeline stage; consumes its instruction, PC, abort and 2-bit taken state.
- Detects ARM B/BL instructions whose predicted state is WT or ST and computes the branch target.
- Issues a one-cycle fetch redirect, the clear_from_decode source that flushes fetch and predictor.
- Registers everything toward decode, including the taken state, so the ALU can later confirm or clear.

Parameters:
- PC_WIDTH, 32, width of all PC/target buses.
- CNT_WIDTH, 16, width of the saturating predicted-taken event counter.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear_from_writeback  in  1  highest-priority flush.
- i_data_stall  in  1  memory stall; hold all state.
- i_clear_from_alu  in  1  ALU mispredict flush.
- i_stall_from_shifter  in  1  hold.
- i_stall_from_issue  in  1  hold.
- i_cpsr_t  in  1  Thumb state; when 1, never predict.
- i_inst  in  32  instruction from the predictor stage.
- i_val  in  1  instruction valid.
- i_abt  in  1  instruction abort.
- i_pc  in  PC_WIDTH  instruction address.
- i_pc_plus_8  in  PC_WIDTH  address plus 8.
- i_taken  in  2  predictor state: 0 SNT, 1 WNT, 2 WT, 3 ST.
- o_inst_ff  out  32  registered instruction.
- o_val_ff  out  1  registered valid.
- o_abt_ff  out  1  registered abort.
- o_pc_ff  out  PC_WIDTH  registered PC.
- o_pc_plus_8_ff  out  PC_WIDTH  registered PC+8.
- o_taken_ff  out  2  registered taken state.
- o_clear_from_decode  out  1  registered redirect pulse.
- o_pc_from_decode  out  PC_WIDTH  registered redirect target.
- o_pred_cnt  out  CNT_WIDTH  saturating count of redirects issued.

Behaviour:
- Reset (async, i_reset_n=0):
  - inst, val, abt, pc, taken, clear, target and cnt = 0.
  - pc_plus_8 = 8.
  - FSM = IDLE.
- Priority each clock edge:
  - clear_from_writeback: clear.
  - data_stall: hold.
  - clear_from_alu: clear.
  - stall_from_shifter: hold.
  - stall_from_issue: hold.
  - otherwise: advance.
- Clear:
  - Outputs go to their reset values except o_pred_cnt, which is kept.
  - FSM returns to IDLE.
- Hold:
  - All registers keep their values.
  - o_clear_from_decode is forced to 0 on the first held cycle, and a redirect is never re-issued for the same instruction.
- Predict condition, evaluated on the inputs:
  - i_val=1, i_abt=0, i_cpsr_t=0.
  - i_inst[27:25]=3'b101 and i_inst[31:28]!=4'b1111.
  - i_taken[1]=1.
- Target = i_pc_plus_8 + (sign_extend(i_inst[23:0]) << 2), computed modulo 2^PC_WIDTH.
- Advance in IDLE:
  - Latch all pipeline inputs into the outputs.
  - If the predict condition holds: o_clear_from_decode <= 1, o_pc_from_decode <= target, o_pred_cnt increments (saturating at all-ones), FSM -> SQUASH.
  - Otherwise o_clear_from_decode <= 0.
- SQUASH, exactly one advancing cycle:
  - Incoming i_val is wrong-path; latch it with o_val_ff <= 0 and force o_clear_from_decode <= 0.
  - Then FSM -> IDLE. A branch arriving in SQUASH is never predicted.
- Stalls while in SQUASH keep the FSM in SQUASH.
- Latency:
  - Pipeline outputs: 1 cycle.
  - Redirect: asserted in the same cycle the branch appears on o_*_ff, high for exactly one cycle.
- The predicted-taken branch itself remains valid downstream with o_taken_ff = WT/ST so the ALU confirms or clears it.
- A simultaneous clear_from_alu with a predicted branch: the clear wins and no redirect is issued.

Decomposition:
- Shared package/include holds:
  - Taken-state constants SNT/WNT/WT/ST, shared with the predictor stage.
  - Branch opcode field constants.
  - FSM state encodings IDLE=0, SQUASH=1.
- Sub-module zap_branch_target_calc: a combinational sign-extend, shift and add producing the target and an is_branch flag.

Test Plan:
- PC=0x100, inst=0xEA000010, taken=ST, val=1 -> next cycle o_clear_from_decode=1 and o_pc_from_decode=0x148 for one cycle; o_pred_cnt=1; following cycle o_val_ff=0 (squash).
- PC=0x200, inst=0xEAFFFFFE, taken=WT -> target=0x200; same-cycle redirect; backward wrap of sign extension correct.
- inst=0xEA000010, taken=WNT (and separately i_abt=1, i_cpsr_t=1, cond=0xF) -> no redirect; o_val_ff=1; o_taken_ff passes through.
- Predicted branch latched, then i_stall_from_issue high for 3 cycles -> redirect high 1 cycle only; outputs held; FSM stays SQUASH until first advance.
- i_clear_from_alu and a predictable branch in the same cycle -> o_val_ff=0, no redirect, o_pc_plus_8_ff=8; i_data_stall together with i_clear_from_alu -> hold wins.
- Deassert i_reset_n mid-SQUASH (async) -> outputs zero immediately, pc_plus_8=8, cnt=0; preload cnt near 0xFFFF and issue 2 redirects -> saturates at 0xFFFF.
